// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants for the block-RAM FIFO controller: RAM geometry,
// write-mask value and output buffer sizing, plus the buffer occupancy helper.
package bram_fifo_ctrl_pkg;

  // SB_RAM40_4K in 256x16 mode, registered read, no read/write cascading
  localparam int RAM_ADDR_W     = 8;
  localparam int RAM_DATA_W     = 16;
  localparam int RAM_READ_MODE  = 0;
  localparam int RAM_WRITE_MODE = 0;

  // MASK bit = 0 means that bit is written
  localparam logic [15:0] MASK_WRITE_ALL = 16'h0000;

  // Words held after the RAM so a full-rate stream survives the read latency
  localparam int OUT_BUF_DEPTH = 2;

  // Output buffer occupancy after one edge of push/pop activity
  function automatic logic [1:0] buf_occ_next(input logic [1:0] cnt,
                                              input logic       push,
                                              input logic       pop);
    return cnt + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Producer/consumer valid-ready streams of the block-RAM FIFO.
// slave: the FIFO side; master: the side that writes and reads the FIFO.
interface bram_fifo_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/bram_fifo_ctrl_out_buf.sv
// fwft_out_buf: 2-entry first-word-fall-through buffer fed by the RAM read
// port. Entry 0 is always the head; push and pop in one cycle both take effect.
module fwft_out_buf
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_mem0;
  logic [DATA_W-1:0] r_mem1;
  logic [1:0]        r_cnt;
  logic              w_pop;
  logic              w_push;

  // A pop of an empty buffer or a push into a full one without a pop is ignored
  assign w_pop  = i_pop & (r_cnt != 2'd0);
  assign w_push = i_push & ((r_cnt != 2'(OUT_BUF_DEPTH)) | w_pop);

  assign o_count = r_cnt;
  assign o_head  = r_mem0;

  // Shift-style storage: the head moves up from entry 1 when popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      r_cnt <= buf_occ_next(r_cnt, w_push, w_pop);
      unique case (r_cnt)
        2'd0: begin
          if (w_push) r_mem0 <= i_push_data;
        end
        2'd1: begin
          if (w_pop) begin
            if (w_push) r_mem0 <= i_push_data;
          end else if (w_push) begin
            r_mem1 <= i_push_data;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_mem0 <= r_mem1;
            if (w_push) r_mem1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: pointer/flag controller running one SB_RAM40_4K as a
// synchronous FWFT FIFO with one word per cycle throughput.
// Optional feature macro: BRAM_FIFO_LEVEL_EN adds the registered level/afull
// outputs; without it those ports and their logic do not exist.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  parameter int AFULL_LVL = 240
`endif
) (
  input  logic                clk,
  input  logic                rst,
  bram_fifo_ctrl_if.slave     fifo,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_mask,
  output logic [ADDR_W-1:0]   ram_raddr,
  output logic                ram_re,
  input  logic [DATA_W-1:0]   ram_rdata
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W+1:0]   level,
  output logic                afull
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_pending;

  logic [ADDR_W:0]   w_ram_cnt_nxt;
  logic              w_wr_fire;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_buf_cnt;
  logic [DATA_W-1:0] w_head;
  logic [2:0]        w_inflight;

  // Full only looks at the registered RAM count, so a read issued this cycle
  // never frees room for a write in the same cycle.
  assign fifo.wr_ready = (r_ram_cnt != DEPTH);
  assign w_wr_fire     = fifo.wr_valid & fifo.wr_ready;

  assign fifo.rd_valid = (w_buf_cnt != 2'd0);
  assign fifo.rd_data  = w_head;
  assign w_pop         = fifo.rd_valid & fifo.rd_ready;

  // Words that will occupy the output buffer once the read in flight lands;
  // a new read is issued only when its result is guaranteed a free slot.
  // Because r_ram_cnt is registered, a word written on this edge is not
  // readable until the next cycle.
  assign w_inflight = {1'b0, w_buf_cnt} + {2'b0, r_pending} - {2'b0, w_pop};
  assign w_issue    = (r_ram_cnt != '0) && (w_inflight < 3'd2);

  assign ram_we    = w_wr_fire;
  assign ram_waddr = r_wptr;
  assign ram_wdata = fifo.wr_data;
  assign ram_mask  = DATA_W'(MASK_WRITE_ALL);
  assign ram_re    = w_issue;
  assign ram_raddr = r_rptr;

  // RAM occupancy: simultaneous write and read issue cancel out
  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    unique case ({w_wr_fire, w_issue})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + (ADDR_W+1)'(1);
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - (ADDR_W+1)'(1);
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase
  end

  // Write/read pointers, RAM count and the one-cycle read-in-flight marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_fire) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_issue)   r_rptr <= r_rptr + ADDR_W'(1);
      r_ram_cnt <= w_ram_cnt_nxt;
      r_pending <= w_issue;
    end
  end

  // RAM read data lands one edge after issue and goes straight into the buffer
  fwft_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pending),
    .i_push_data (ram_rdata),
    .i_pop       (w_pop),
    .o_count     (w_buf_cnt),
    .o_head      (w_head)
  );

`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR_W+1:0] r_level;
  logic              r_afull;
  logic [1:0]        w_buf_cnt_nxt;
  logic [ADDR_W+1:0] w_level_nxt;

  assign w_buf_cnt_nxt = buf_occ_next(w_buf_cnt, r_pending, w_pop);
  assign w_level_nxt   = (ADDR_W+2)'(w_ram_cnt_nxt) + (ADDR_W+2)'(w_issue)
                       + (ADDR_W+2)'(w_buf_cnt_nxt);

  // Level reflects the state right after each edge, so it tracks handshakes exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_afull <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_afull <= (w_level_nxt >= (ADDR_W+2)'(AFULL_LVL));
    end
  end

  assign level = r_level;
  assign afull = r_afull;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: 256x16 RAM model with registered read, a queue
// model of the FIFO contents checked every cycle, and directed scenarios.
module tb_bram_fifo_ctrl;
  import bram_fifo_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bram_fifo_ctrl_if #(.DATA_W(DW)) fifo ();

  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_mask, ram_rdata;
  logic          ram_we, ram_re;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  logic          afull;
`endif

  bram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (fifo),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_mask  (ram_mask),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    .level     (level),
    .afull     (afull)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of accepted-but-not-consumed words, plus write/read counts
  logic [DW-1:0] q[$];
  int  wcnt = 0;
  int  rcnt = 0;
  bit  mon_en = 1'b0;

  task automatic model_clear();
    q.delete();
    wcnt = 0;
    rcnt = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      int occ;
      occ = q.size();
      chk("mask", ram_mask, 0);
      chk("we", ram_we, fifo.wr_valid & fifo.wr_ready);
`ifdef BRAM_FIFO_LEVEL_EN
      chk("level", level, occ);
      chk("afull", afull, occ >= 240);
`endif
      if (fifo.wr_ready) chk("ready_room", occ < 258, 1);
      else               chk("full_occ", occ >= 256, 1);
      if (ram_re) begin
        chk("re_committed", rcnt < wcnt, 1);
        chk("raddr", ram_raddr, rcnt % 256);
        rcnt++;
      end
      if (fifo.rd_valid) begin
        chk("rd_nonempty", occ > 0, 1);
        if (occ > 0) begin
          chk("rd_data", fifo.rd_data, q[0]);
          if (fifo.rd_ready) void'(q.pop_front());
        end
      end
      if (fifo.wr_valid && fifo.wr_ready) begin
        chk("waddr", ram_waddr, wcnt % 256);
        chk("wdata", ram_wdata, fifo.wr_data);
        q.push_back(fifo.wr_data);
        wcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted, n, sent, recv, first, bubble;
    bit found;

    fifo.wr_valid = 1'b0;
    fifo.wr_data  = '0;
    fifo.rd_ready = 1'b0;

    // 1: asynchronous reset with no clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_ready", fifo.wr_ready, 1);
    chk("rst_rd_valid", fifo.rd_valid, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_rd_data", fifo.rd_data, 0);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("rst_level", level, 0);
    chk("rst_afull", afull, 0);
`endif
    #1 rst = 1'b0;
    mon_en = 1'b1;
    tick();
    tick();

    // 2: single word latency and hold
    fifo.wr_valid = 1'b1;
    fifo.wr_data  = 16'hA5A5;
    tick();
    fifo.wr_valid = 1'b0;
    chk("lat_k", fifo.rd_valid, 0);
    tick();
    chk("lat_k1", fifo.rd_valid, 0);
    tick();
    chk("lat_k2_valid", fifo.rd_valid, 1);
    chk("lat_k2_data", fifo.rd_data, 16'hA5A5);
    repeat (10) begin
      tick();
      chk("hold_valid", fifo.rd_valid, 1);
      chk("hold_data", fifo.rd_data, 16'hA5A5);
    end
    fifo.rd_ready = 1'b1;
    tick();
    fifo.rd_ready = 1'b0;
    chk("single_drained", fifo.rd_valid, 0);

    // 3: fill with no reads, then drain
    accepted = 0;
    for (int i = 0; i < 300; i++) begin
      fifo.wr_valid = 1'b1;
      fifo.wr_data  = 16'(i);
      @(negedge clk);
      if (fifo.wr_ready) accepted++;
      tick();
    end
    fifo.wr_valid = 1'b0;
    chk("fill_count", accepted, 258);
    chk("fill_ready", fifo.wr_ready, 0);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("fill_level", level, 258);
    chk("fill_afull", afull, 1);
`endif
    n = 0;
    fifo.rd_ready = 1'b1;
    for (int c = 0; c < 400 && n < 258; c++) begin
      @(negedge clk);
      if (fifo.rd_valid) begin
        chk("drain_val", fifo.rd_data, n);
        n++;
      end
      tick();
    end
    fifo.rd_ready = 1'b0;
    chk("drain_count", n, 258);
    tick();
    chk("drain_empty", fifo.rd_valid, 0);
    chk("drain_ready", fifo.wr_ready, 1);

    // 4: full-rate streaming
    sent = 0; recv = 0; first = -1; bubble = 0;
    fifo.rd_ready = 1'b1;
    for (int c = 0; c < 1100 && recv < 1000; c++) begin
      fifo.wr_valid = (sent < 1000);
      fifo.wr_data  = 16'(sent);
      @(negedge clk);
      if (fifo.rd_valid) begin
        if (first < 0) first = c;
        chk("stream_data", fifo.rd_data, recv);
        recv++;
      end else if (first >= 0) begin
        bubble++;
      end
      if (fifo.wr_valid && fifo.wr_ready) sent++;
      tick();
    end
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b0;
    chk("stream_first", first, 3);
    chk("stream_bubbles", bubble, 0);
    chk("stream_count", recv, 1000);

    // 5: random stalls on both sides, pointers wrap twice
    sent = 0; recv = 0;
    for (int c = 0; c < 20000 && recv < 600; c++) begin
      fifo.wr_valid = (sent < 600) && ($urandom_range(0, 9) < 7);
      fifo.wr_data  = 16'(1000 + sent);
      fifo.rd_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (fifo.rd_valid && fifo.rd_ready) begin
        chk("rand_data", fifo.rd_data, 1000 + recv);
        recv++;
      end
      if (fifo.wr_valid && fifo.wr_ready) sent++;
      tick();
    end
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b0;
    chk("rand_count", recv, 600);

    // 6: reset in the middle of a partly filled FIFO
    for (int i = 0; i < 100; i++) begin
      fifo.wr_valid = 1'b1;
      fifo.wr_data  = 16'(i + 16'h0700);
      tick();
    end
    fifo.wr_valid = 1'b0;
    repeat (3) tick();
`ifdef BRAM_FIFO_LEVEL_EN
    chk("pre_rst_level", level, 100);
`endif
    chk("pre_rst_valid", fifo.rd_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", fifo.rd_valid, 0);
    chk("mid_rst_ready", fifo.wr_ready, 1);
    model_clear();
    #3 rst = 1'b0;
    tick();
    fifo.wr_valid = 1'b1;
    fifo.wr_data  = 16'h1234;
    tick();
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (fifo.rd_valid) begin
        found = 1'b1;
        chk("post_rst_data", fifo.rd_data, 16'h1234);
      end
      tick();
    end
    fifo.rd_ready = 1'b0;
    chk("post_rst_found", found, 1);
    tick();
    chk("post_rst_empty", fifo.rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
